// File: rtl/apb_master_mc.sv
// Multi-slave APB master: turns valid/ready commands into SETUP/ACCESS transfers and returns one registered response.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_mc #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int DEC_BITS   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
    logic [NUM_SLAVES-1:0]   psel_reg, psel_next;
    logic                    penable_reg, penable_next;
    logic                    pwrite_reg, pwrite_next;
    logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                    rsp_err_reg, rsp_err_next;

    logic [DEC_BITS-1:0]     idx;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic                    idx_ok;
    logic [DATA_WIDTH-1:0]   rdata_slice [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    sel_ready;
    logic                    sel_err;

    assign idx    = cmd_addr[ADDR_WIDTH-1 -: DEC_BITS];
    assign idx_ok = |dec_onehot;

    // An index beyond NUM_SLAVES leaves dec_onehot all-zero, which flags the decode error.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign dec_onehot[gi]  = (idx == DEC_BITS'(gi));
            assign rdata_slice[gi] = prdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_reg[i]) begin
                sel_rdata = sel_rdata | rdata_slice[i];
                sel_ready = sel_ready | pready[i];
                sel_err   = sel_err | pslverr[i];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] count_reg, count_next;
    logic        timeout_hit;

    assign timeout_hit = (count_reg == 16'(TIMEOUT - 1));
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT);
`endif

    always_comb begin
        state_next     = state_reg;
        paddr_next     = paddr_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        pwdata_next    = pwdata_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
        count_next     = count_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (idx_ok) begin
                        paddr_next   = cmd_addr;
                        pwrite_next  = cmd_write;
                        pwdata_next  = cmd_write ? cmd_wdata : '0;
                        psel_next    = dec_onehot;
                        penable_next = 1'b0;
                        state_next   = SETUP;
                    end else begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                    end
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                count_next   = '0;
`endif
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_next      = '0;
                    penable_next   = 1'b0;
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = sel_err;
                    rsp_rdata_next = (!pwrite_reg && !sel_err) ? sel_rdata : '0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    psel_next      = '0;
                    penable_next   = 1'b0;
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end else begin
                    count_next = count_reg + 16'd1;
                end
`endif
            end
            default: begin
                psel_next    = '0;
                penable_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg     <= IDLE;
            paddr_reg     <= '0;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            paddr_reg     <= paddr_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            pwdata_reg    <= pwdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (preset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
`endif

    assign cmd_ready = (state_reg == IDLE) && !preset;
    assign paddr     = paddr_reg;
    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign pwrite    = pwrite_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
